vec_alu_issue_seq: RTL and testbench

- Parametrised successor to the single-cycle ALU control decoder in the vector CPU control unit.
- Accepts one decoded DP/non-DP vector instruction per handshake and resolves ALUControl/SrcA with the established encoding.
- Sequences the vector over LANES-wide beats, one beat per accepted output, each with lane mask, element base index and last flag.
- Sits between the control unit and the lane-parallel vector ALU. It adds multi-cycle DIV pacing and illegal-funct detection.

---
 rtl/vec_alu_issue_seq_if.sv | 33 +++
 rtl/vec_alu_issue_seq.sv | 241 ++++++++++++++++++++++++
 tb/tb_vec_alu_issue_seq.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/vec_alu_issue_seq_if.sv
// rtl/vec_alu_issue_seq_if.sv - instruction and beat handshake bundle for the vector ALU issue sequencer
interface vec_alu_issue_seq_if #(
  parameter int VLEN_MAX = 16,
  parameter int LANES    = 4
);
  localparam int VW = $clog2(VLEN_MAX + 1);
  localparam int EW = $clog2(VLEN_MAX);

  logic             in_valid;
  logic             in_ready;
  logic             alu_op;
  logic [3:0]       funct;
  logic [VW-1:0]    vlen;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       alu_control;
  logic             src_a;
  logic [LANES-1:0] lane_mask;
  logic [EW-1:0]    elem_base;
  logic             last;
  logic             illegal;
  logic             busy;

  modport master (
    output in_valid, alu_op, funct, vlen, out_ready,
    input  in_ready, out_valid, alu_control, src_a, lane_mask, elem_base, last, illegal, busy
  );

  modport slave (
    input  in_valid, alu_op, funct, vlen, out_ready,
    output in_ready, out_valid, alu_control, src_a, lane_mask, elem_base, last, illegal, busy
  );
endinterface

// File: rtl/vec_alu_issue_seq.sv
// rtl/vec_alu_issue_seq.sv - vector ALU decode and beat sequencer with DIV pacing (optional VEC_ALU_PERF_CNT_EN counters)
module vec_alu_issue_seq #(
  parameter int VLEN_MAX   = 16,
  parameter int LANES      = 4,
  parameter int DIV_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vec_alu_issue_seq_if.slave   bus
`ifdef VEC_ALU_PERF_CNT_EN
  ,
  output logic [31:0]          perf_beats,
  output logic [31:0]          perf_stall,
  output logic [15:0]          perf_illegal
`endif
);
  localparam int VW = $clog2(VLEN_MAX + 1);
  localparam int EW = $clog2(VLEN_MAX);
  localparam int AW = VW + 2;
  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] DIV_INIT = (DIV_CYCLES > 1) ? CW'(DIV_CYCLES - 2) : '0;
  localparam logic [VW-1:0] VMAX     = VW'(VLEN_MAX);
  localparam logic [AW-1:0] LANES_A  = AW'(LANES);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DIV_WAIT = 2'd1;
  localparam logic [1:0] S_ISSUE    = 2'd2;

  logic [1:0]       r_state,       w_nxt_state;
  logic [CW-1:0]    r_div_cnt,     w_nxt_div_cnt;
  logic [VW-1:0]    r_vlen,        w_nxt_vlen;
  logic             r_is_div,      w_nxt_is_div;
  logic             r_out_valid,   w_nxt_out_valid;
  logic [2:0]       r_alu_control, w_nxt_alu_control;
  logic             r_src_a,       w_nxt_src_a;
  logic [LANES-1:0] r_lane_mask,   w_nxt_lane_mask;
  logic [EW-1:0]    r_elem_base,   w_nxt_elem_base;
  logic             r_last,        w_nxt_last;
  logic             r_illegal,     w_nxt_illegal;
  logic             r_in_ready,    w_nxt_in_ready;
  logic             r_busy,        w_nxt_busy;

  logic [2:0]    w_dec_alu;
  logic          w_dec_src;
  logic          w_dec_ill;
  logic          w_dec_div;
  logic [VW-1:0] w_vlen_c;
  logic [AW-1:0] w_next_base;

  // Lane i is enabled when its element index falls inside the clamped vector
  function automatic logic [LANES-1:0] f_mask(input logic [AW-1:0] base, input logic [VW-1:0] len);
    logic [LANES-1:0] m;
    for (int i = 0; i < LANES; i++) begin
      m[i] = (base + AW'(i)) < AW'(len);
    end
    return m;
  endfunction

  assign w_vlen_c    = (bus.vlen > VMAX) ? VMAX : bus.vlen;
  assign w_next_base = AW'(r_elem_base) + LANES_A;

  // Instruction decode into ALUControl/SrcA plus illegal and DIV flags
  always_comb begin
    w_dec_alu = 3'b111;
    w_dec_src = 1'b0;
    w_dec_ill = 1'b0;
    w_dec_div = 1'b0;
    if (bus.alu_op) begin
      case (bus.funct[2:0])
        3'b000: w_dec_alu = 3'b000;
        3'b001: w_dec_alu = 3'b001;
        3'b011: w_dec_alu = 3'b011;
        3'b100: begin
          w_dec_alu = 3'b100;
          w_dec_div = 1'b1;
        end
        3'b101: w_dec_alu = 3'b101;
        3'b010: begin
          if (bus.funct[3]) begin
            w_dec_alu = 3'b000;
            w_dec_src = 1'b1;
          end else begin
            w_dec_ill = 1'b1;
          end
        end
        3'b111: w_dec_ill = ~bus.funct[3];
        default: w_dec_ill = 1'b1;
      endcase
    end
  end

  // Next-state and next-beat computation; every output is then registered
  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_div_cnt     = r_div_cnt;
    w_nxt_vlen        = r_vlen;
    w_nxt_is_div      = r_is_div;
    w_nxt_out_valid   = r_out_valid;
    w_nxt_alu_control = r_alu_control;
    w_nxt_src_a       = r_src_a;
    w_nxt_lane_mask   = r_lane_mask;
    w_nxt_elem_base   = r_elem_base;
    w_nxt_last        = r_last;
    w_nxt_illegal     = r_illegal;
    w_nxt_in_ready    = r_in_ready;
    w_nxt_busy        = r_busy;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_nxt_vlen        = w_vlen_c;
          w_nxt_is_div      = w_dec_div;
          w_nxt_alu_control = w_dec_alu;
          w_nxt_src_a       = w_dec_src;
          w_nxt_illegal     = w_dec_ill;
          w_nxt_elem_base   = '0;
          w_nxt_in_ready    = 1'b0;
          w_nxt_busy        = 1'b1;
          if (w_dec_ill) begin
            w_nxt_lane_mask = '0;
            w_nxt_last      = 1'b1;
          end else begin
            w_nxt_lane_mask = f_mask('0, w_vlen_c);
            w_nxt_last      = AW'(w_vlen_c) <= LANES_A;
          end
          if (w_dec_div && (DIV_CYCLES > 1)) begin
            w_nxt_state   = S_DIV_WAIT;
            w_nxt_div_cnt = DIV_INIT;
          end else begin
            w_nxt_state     = S_ISSUE;
            w_nxt_out_valid = 1'b1;
          end
        end
      end
      S_DIV_WAIT: begin
        if (r_div_cnt == '0) begin
          w_nxt_state     = S_ISSUE;
          w_nxt_out_valid = 1'b1;
        end else begin
          w_nxt_div_cnt = r_div_cnt - 1'b1;
        end
      end
      S_ISSUE: begin
        if (bus.out_ready) begin
          if (r_last) begin
            w_nxt_state     = S_IDLE;
            w_nxt_out_valid = 1'b0;
            w_nxt_in_ready  = 1'b1;
            w_nxt_busy      = 1'b0;
          end else begin
            w_nxt_elem_base = w_next_base[EW-1:0];
            w_nxt_lane_mask = f_mask(w_next_base, r_vlen);
            w_nxt_last      = (w_next_base + LANES_A) >= AW'(r_vlen);
            if (r_is_div && (DIV_CYCLES > 1)) begin
              w_nxt_state     = S_DIV_WAIT;
              w_nxt_div_cnt   = DIV_INIT;
              w_nxt_out_valid = 1'b0;
            end
          end
        end
      end
      default: begin
        w_nxt_state     = S_IDLE;
        w_nxt_out_valid = 1'b0;
        w_nxt_in_ready  = 1'b1;
        w_nxt_busy      = 1'b0;
      end
    endcase
  end

  // State and beat registers; reset drops any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_div_cnt     <= '0;
      r_vlen        <= '0;
      r_is_div      <= 1'b0;
      r_out_valid   <= 1'b0;
      r_alu_control <= 3'b111;
      r_src_a       <= 1'b0;
      r_lane_mask   <= '0;
      r_elem_base   <= '0;
      r_last        <= 1'b0;
      r_illegal     <= 1'b0;
      r_in_ready    <= 1'b1;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_div_cnt     <= w_nxt_div_cnt;
      r_vlen        <= w_nxt_vlen;
      r_is_div      <= w_nxt_is_div;
      r_out_valid   <= w_nxt_out_valid;
      r_alu_control <= w_nxt_alu_control;
      r_src_a       <= w_nxt_src_a;
      r_lane_mask   <= w_nxt_lane_mask;
      r_elem_base   <= w_nxt_elem_base;
      r_last        <= w_nxt_last;
      r_illegal     <= w_nxt_illegal;
      r_in_ready    <= w_nxt_in_ready;
      r_busy        <= w_nxt_busy;
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.alu_control = r_alu_control;
  assign bus.src_a       = r_src_a;
  assign bus.lane_mask   = r_lane_mask;
  assign bus.elem_base   = r_elem_base;
  assign bus.last        = r_last;
  assign bus.illegal     = r_illegal;
  assign bus.busy        = r_busy;

`ifdef VEC_ALU_PERF_CNT_EN
  logic [31:0] r_perf_beats;
  logic [31:0] r_perf_stall;
  logic [15:0] r_perf_illegal;

  // Saturating counters for beat handshakes, stalled beats and illegal accepts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_beats   <= '0;
      r_perf_stall   <= '0;
      r_perf_illegal <= '0;
    end else begin
      if (r_out_valid && bus.out_ready && (r_perf_beats != '1)) begin
        r_perf_beats <= r_perf_beats + 1'b1;
      end
      if (r_out_valid && !bus.out_ready && (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + 1'b1;
      end
      if ((r_state == S_IDLE) && bus.in_valid && w_dec_ill && (r_perf_illegal != '1)) begin
        r_perf_illegal <= r_perf_illegal + 1'b1;
      end
    end
  end

  assign perf_beats   = r_perf_beats;
  assign perf_stall   = r_perf_stall;
  assign perf_illegal = r_perf_illegal;
`endif
endmodule

// File: tb/tb_vec_alu_issue_seq.sv
// tb/tb_vec_alu_issue_seq.sv - directed self-checking bench for vec_alu_issue_seq
module tb_vec_alu_issue_seq;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  vec_alu_issue_seq_if #(.VLEN_MAX(16), .LANES(4)) bus_if ();

`ifdef VEC_ALU_PERF_CNT_EN
  logic [31:0] perf_beats;
  logic [31:0] perf_stall;
  logic [15:0] perf_illegal;
`endif

  vec_alu_issue_seq #(.VLEN_MAX(16), .LANES(4), .DIV_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
`ifdef VEC_ALU_PERF_CNT_EN
    ,
    .perf_beats   (perf_beats),
    .perf_stall   (perf_stall),
    .perf_illegal (perf_illegal)
`endif
  );

  // {out_valid, alu_control, src_a, lane_mask, elem_base, last, illegal}
  logic [14:0] obs;
  logic [1:0]  st;
  assign obs = {bus_if.out_valid, bus_if.alu_control, bus_if.src_a, bus_if.lane_mask,
                bus_if.elem_base, bus_if.last, bus_if.illegal};
  assign st  = {bus_if.in_ready, bus_if.busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic op, input logic [3:0] f, input logic [4:0] vl);
    bus_if.in_valid = 1'b1;
    bus_if.alu_op   = op;
    bus_if.funct    = f;
    bus_if.vlen     = vl;
    tick();
    bus_if.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.alu_op    = 1'b0;
    bus_if.funct     = 4'h0;
    bus_if.vlen      = 5'd0;
    bus_if.out_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    n_checks++;
    if (obs !== {1'b0, 3'b111, 1'b0, 4'b0000, 4'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_beat: got %h want %h", obs, {1'b0, 3'b111, 1'b0, 4'b0000, 4'd0, 1'b0, 1'b0});
    end
    n_checks++;
    if (st !== 2'b10) begin n_fail++; $display("FAIL reset_status: got %b want 10", st); end
    bus_if.out_ready = 1'b1;
    tick();
    n_checks++;
    if (obs[14] !== 1'b0) begin n_fail++; $display("FAIL reset_idle_ready_ignored: out_valid %b want 0", obs[14]); end
  endtask

  task automatic test_add();
    bus_if.out_ready = 1'b1;
    accept(1'b1, 4'b0000, 5'd10);
    n_checks++;
    if (obs !== {1'b1, 3'b000, 1'b0, 4'b1111, 4'd0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL add_b0: got %h", obs); end
    n_checks++;
    if (st !== 2'b01) begin n_fail++; $display("FAIL add_busy: got %b want 01", st); end
    tick();
    n_checks++;
    if (obs !== {1'b1, 3'b000, 1'b0, 4'b1111, 4'd4, 1'b0, 1'b0}) begin n_fail++; $display("FAIL add_b1: got %h", obs); end
    tick();
    n_checks++;
    if (obs !== {1'b1, 3'b000, 1'b0, 4'b0011, 4'd8, 1'b1, 1'b0}) begin n_fail++; $display("FAIL add_b2: got %h", obs); end
    tick();
    n_checks++;
    if ({obs[14], st} !== 3'b010) begin n_fail++; $display("FAIL add_done: got %b want 010", {obs[14], st}); end
  endtask

  task automatic test_mov_illegal();
    bus_if.out_ready = 1'b1;
    accept(1'b1, 4'b1010, 5'd4);
    n_checks++;
    if (obs !== {1'b1, 3'b000, 1'b1, 4'b1111, 4'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL mov_beat: got %h", obs); end
    tick();
    n_checks++;
    if (st !== 2'b10) begin n_fail++; $display("FAIL mov_done: got %b want 10", st); end
    accept(1'b1, 4'b0010, 5'd5);
    n_checks++;
    if (obs !== {1'b1, 3'b111, 1'b0, 4'b0000, 4'd0, 1'b1, 1'b1}) begin n_fail++; $display("FAIL illegal_0010: got %h", obs); end
    tick();
    accept(1'b1, 4'b0111, 5'd8);
    n_checks++;
    if (obs !== {1'b1, 3'b111, 1'b0, 4'b0000, 4'd0, 1'b1, 1'b1}) begin n_fail++; $display("FAIL illegal_0111: got %h", obs); end
    tick();
    accept(1'b1, 4'b1111, 5'd4);
    n_checks++;
    if (obs !== {1'b1, 3'b111, 1'b0, 4'b1111, 4'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL dup_beat: got %h", obs); end
    tick();
  endtask

  task automatic test_div();
    int n;
    bus_if.out_ready = 1'b1;
    accept(1'b1, 4'b0100, 5'd8);
    n = 0;
    while (!bus_if.out_valid && n < 20) begin tick(); n++; end
    n_checks++;
    if (n !== 3) begin n_fail++; $display("FAIL div_first_latency: waited %0d want 3", n); end
    n_checks++;
    if (obs !== {1'b1, 3'b100, 1'b0, 4'b1111, 4'd0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL div_b0: got %h", obs); end
    tick();
    n = 0;
    while (!bus_if.out_valid && n < 20) begin tick(); n++; end
    n_checks++;
    if (n !== 3) begin n_fail++; $display("FAIL div_second_latency: waited %0d want 3", n); end
    n_checks++;
    if (obs !== {1'b1, 3'b100, 1'b0, 4'b1111, 4'd4, 1'b1, 1'b0}) begin n_fail++; $display("FAIL div_b1: got %h", obs); end
    tick();
    n_checks++;
    if ({obs[14], st} !== 3'b010) begin n_fail++; $display("FAIL div_done: got %b want 010", {obs[14], st}); end
  endtask

  task automatic test_backpressure();
    bus_if.out_ready = 1'b0;
    accept(1'b1, 4'b0001, 5'd8);
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if ({obs, st} !== {1'b1, 3'b001, 1'b0, 4'b1111, 4'd0, 1'b0, 1'b0, 2'b01}) begin
        n_fail++; $display("FAIL bp_hold_%0d: got %h", c, {obs, st});
      end
      tick();
    end
    bus_if.out_ready = 1'b1;
    n_checks++;
    if (obs !== {1'b1, 3'b001, 1'b0, 4'b1111, 4'd0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL bp_b0_release: got %h", obs); end
    tick();
    n_checks++;
    if (obs !== {1'b1, 3'b001, 1'b0, 4'b1111, 4'd4, 1'b1, 1'b0}) begin n_fail++; $display("FAIL bp_b1: got %h", obs); end
    tick();
    n_checks++;
    if ({obs[14], st} !== 3'b010) begin n_fail++; $display("FAIL bp_done: got %b want 010", {obs[14], st}); end
  endtask

  task automatic test_vlen_edges();
    logic [14:0] exp;
    bus_if.out_ready = 1'b1;
    accept(1'b1, 4'b0000, 5'd0);
    n_checks++;
    if (obs !== {1'b1, 3'b000, 1'b0, 4'b0000, 4'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL vlen0_beat: got %h", obs); end
    tick();
    accept(1'b1, 4'b1000, 5'd31);
    for (int b = 0; b < 4; b++) begin
      exp = {1'b1, 3'b000, 1'b0, 4'b1111, 4'(b * 4), (b == 3), 1'b0};
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL vlen31_b%0d: got %h want %h", b, obs, exp); end
      tick();
    end
    n_checks++;
    if ({obs[14], st} !== 3'b010) begin n_fail++; $display("FAIL vlen31_done: got %b want 010", {obs[14], st}); end
    accept(1'b0, 4'b0101, 5'd3);
    n_checks++;
    if (obs !== {1'b1, 3'b111, 1'b0, 4'b0111, 4'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL nondp_beat: got %h", obs); end
    tick();
  endtask

  task automatic test_reset_mid();
    bus_if.out_ready = 1'b1;
    accept(1'b1, 4'b0011, 5'd16);
    tick();
    n_checks++;
    if (obs !== {1'b1, 3'b011, 1'b0, 4'b1111, 4'd4, 1'b0, 1'b0}) begin n_fail++; $display("FAIL mul_b1: got %h", obs); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({obs, st} !== {1'b0, 3'b111, 1'b0, 4'b0000, 4'd0, 1'b0, 1'b0, 2'b10}) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %h", {obs, st});
    end
    #2 rst_n = 1'b1;
    tick();
    n_checks++;
    if (obs[14] !== 1'b0) begin n_fail++; $display("FAIL mid_reset_no_partial: out_valid %b want 0", obs[14]); end
    accept(1'b1, 4'b0011, 5'd8);
    n_checks++;
    if (obs !== {1'b1, 3'b011, 1'b0, 4'b1111, 4'd0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL post_reset_b0: got %h", obs); end
    tick();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_add();
    test_mov_illegal();
    test_div();
    test_backpressure();
    test_vlen_edges();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
